// File: rtl/seg7_pkg.sv
// Shared constants and scan-state encoding for the two-digit 7-segment scan path.
// Patterns are internal positive logic: bit 6 = segment a ... bit 0 = segment g, 1 = lit.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [6:0] SEG_ZERO = 7'b1111110;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    GAP0 = 2'd1,
    DIG1 = 2'd2,
    GAP1 = 2'd3
  } scan_state_t;

  // Converts an internal lit pattern to pin levels.
  function automatic logic [6:0] seg_pins(input logic [6:0] lit, input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Input-pattern and display-pin bundle of the scan multiplexer.
// The slave side is the multiplexer; the master side is whatever feeds it.
interface seg_scan_mux_if;

  logic       enable;
  logic       load;
  logic [6:0] led_1;
  logic [6:0] led_0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_start;

  modport master (
    output enable,
    output load,
    output led_1,
    output led_0,
    input  seg,
    input  an,
    input  frame_start
  );

  modport slave (
    input  enable,
    input  load,
    input  led_1,
    input  led_0,
    output seg,
    output an,
    output frame_start
  );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter and DIG0/GAP0/DIG1/GAP1 sequencer; reports the current slot and
// a pulse on the clock edge that starts a new frame in DIG0.
module seg_scan_timer
  import seg7_pkg::*;
#(
  parameter logic [15:0] CLK_DIV      = 16'd50000,
  parameter logic [7:0]  BLANK_CYCLES = 8'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output scan_state_t state,
  output logic        run,
  output logic        frame_pulse,
  output logic        enter
);

  scan_state_t state_reg;
  scan_state_t state_next;
  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;
  logic        run_reg;
  logic        run_next;
  logic [15:0] limit;
  logic        last;

  // run_reg low means "parked before DIG0": the next enabled edge is a fresh frame entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DIG0;
      cnt_reg   <= 16'd0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      run_reg   <= run_next;
    end
  end

  always_comb begin
    limit      = ((state_reg == DIG0) || (state_reg == DIG1)) ? CLK_DIV : {8'd0, BLANK_CYCLES};
    last       = (cnt_reg == (limit - 16'd1));
    state_next = state_reg;
    cnt_next   = cnt_reg + 16'd1;
    run_next   = run_reg;
    enter      = 1'b0;

    if (!enable) begin
      state_next = DIG0;
      cnt_next   = 16'd0;
      run_next   = 1'b0;
    end else if (!run_reg) begin
      state_next = DIG0;
      cnt_next   = 16'd0;
      run_next   = 1'b1;
      enter      = 1'b1;
    end else if (last) begin
      cnt_next = 16'd0;
      unique case (state_reg)
        DIG0:    state_next = (BLANK_CYCLES == 8'd0) ? DIG1 : GAP0;
        GAP0:    state_next = DIG1;
        DIG1:    state_next = (BLANK_CYCLES == 8'd0) ? DIG0 : GAP1;
        GAP1:    state_next = DIG0;
        default: state_next = DIG0;
      endcase
      enter = (state_next == DIG0);
    end
  end

  assign state       = state_reg;
  assign run         = run_reg;
  assign frame_pulse = run_reg && (state_reg == DIG0) && (cnt_reg == 16'd0);

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit 7-segment scan multiplexer: double-buffered patterns committed at frame
// entry, blanking gaps between digits, optional tens leading-zero blanking.
module seg_scan_mux
  import seg7_pkg::*;
#(
  parameter logic [15:0] CLK_DIV        = 16'd50000,
  parameter logic [7:0]  BLANK_CYCLES   = 8'd4,
  parameter logic        SEG_ACTIVE_LOW = 1'b0,
  parameter logic        AN_ACTIVE_LOW  = 1'b1,
  parameter logic        LZ_BLANK       = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_mux_if.slave  bus
);

  localparam logic [6:0] SEG_IDLE = {7{SEG_ACTIVE_LOW}};
  localparam logic [1:0] AN_IDLE  = {2{AN_ACTIVE_LOW}};

  scan_state_t state;
  logic        run;
  logic        frame_pulse;
  logic        enter;

  logic [6:0]  led_in [2];
  logic [6:0]  sh_reg [2];
  logic [6:0]  ac_reg [2];

  logic [6:0]  seg_lit;
  logic [1:0]  an_lit;
  logic        fs_next;
  logic [6:0]  seg_reg;
  logic [1:0]  an_reg;
  logic        fs_reg;

  seg_scan_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (bus.enable),
    .state       (state),
    .run         (run),
    .frame_pulse (frame_pulse),
    .enter       (enter)
  );

  assign led_in[0] = bus.led_0;
  assign led_in[1] = bus.led_1;

  // A load coinciding with the commit edge bypasses the shadow so it lands this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sh_reg[i] <= SEG_OFF;
        ac_reg[i] <= SEG_OFF;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.load) begin
          sh_reg[i] <= led_in[i];
        end
        if (enter) begin
          ac_reg[i] <= bus.load ? led_in[i] : sh_reg[i];
        end
      end
    end
  end

  always_comb begin
    seg_lit = SEG_OFF;
    an_lit  = 2'b00;
    fs_next = 1'b0;
    if (bus.enable && run) begin
      fs_next = frame_pulse;
      unique case (state)
        DIG0: begin
          seg_lit = ac_reg[0];
          an_lit  = 2'b01;
        end
        DIG1: begin
          if (!(LZ_BLANK && (ac_reg[1] == SEG_ZERO))) begin
            seg_lit = ac_reg[1];
            an_lit  = 2'b10;
          end
        end
        default: begin
          seg_lit = SEG_OFF;
          an_lit  = 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= SEG_IDLE;
      an_reg  <= AN_IDLE;
      fs_reg  <= 1'b0;
    end else begin
      seg_reg <= seg_pins(seg_lit, SEG_ACTIVE_LOW);
      an_reg  <= an_lit ^ AN_IDLE;
      fs_reg  <= fs_next;
    end
  end

  assign bus.seg         = seg_reg;
  assign bus.an          = an_reg;
  assign bus.frame_start = fs_reg;

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Two-digit 7-segment scan multiplexer placed directly downstream of the binary-to-BCD/segment-decode stage. It takes the decoded tens and units patterns on a shared segment bus, with one digit enable per digit, and refreshes them one digit at a time. A blanking gap between the two digits prevents ghosting. Input patterns are double-buffered and committed only at frame boundaries, so the display never shows one digit from an old value and one from a new value.

## Interface
Parameters:
- CLK_DIV, 16'd50000, clock cycles each digit is lit per slot (≥1)
- BLANK_CYCLES, 8'd4, dead cycles after each digit with all digits off (0 disables the gaps)
- SEG_ACTIVE_LOW, 1'b0, 1 inverts seg outputs at the pins
- AN_ACTIVE_LOW, 1'b1, 1 makes an outputs active-low
- LZ_BLANK, 1'b1, 1 blanks the tens digit when its pattern is "0" (7'b1111110)

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- enable, in, 1, scan enable; low forces the display off
- load, in, 1, one-cycle strobe that captures led_1/led_0 into the shadow buffer
- led_1, in, 7, tens pattern, bit 6 = segment a … bit 0 = segment g, 1 = lit
- led_0, in, 7, units pattern, same encoding
- seg, out, 7, registered segment bus, polarity per SEG_ACTIVE_LOW
- an, out, 2, registered digit enables; an[1] = tens, an[0] = units; polarity per AN_ACTIVE_LOW
- frame_start, out, 1, one-cycle registered pulse on the first lit cycle of DIG0

## Operation
- Shadow registers sh1/sh0 load from led_1/led_0 on any cycle with load=1.
- Active registers ac1/ac0 load from the shadow registers on the cycle the FSM enters DIG0.
  - If load=1 on that same cycle, led_1/led_0 bypass straight into ac1/ac0.
- FSM states and transitions:
  - DIG0 → GAP0 → DIG1 → GAP1 → DIG0.
  - Each DIGn state lasts CLK_DIV cycles. Each GAPn state lasts BLANK_CYCLES cycles.
  - With BLANK_CYCLES=0, the GAP states are skipped: DIG0 → DIG1 → DIG0.
- Slot counter: 16 bits. It counts 0..limit-1 in each state, clears on every state change, and never wraps mid-state.
- Pattern selection:
  - DIG0 drives ac0 with only an[0] asserted.
  - DIG1 drives ac1 with only an[1] asserted.
  - GAPn drives seg=off and an=off.
- Leading-zero blanking: if LZ_BLANK=1 and ac1==7'b1111110, DIG1 drives seg=off and an=off.
  - The slot timing is unchanged, so frame length stays constant.
- Polarity is applied once, at the output registers. Internally, logic 1 always means lit/enabled.
- enable=0:
  - FSM is forced to DIG0 with the counter at 0.
  - Outputs are off; frame_start=0.
  - Shadow loads continue.
  - On the first cycle after enable returns to 1, the FSM enters DIG0 fresh, which commits the shadow registers.

## Timing
- Reset values:
  - state=DIG0, counter=0; sh/ac registers all 0.
  - seg and an at their inactive pin levels.
  - frame_start=0.
- After rst_n deasserts, the first clock is treated as entry to DIG0, which commits the shadow registers and pulses frame_start.
- Latency: outputs are registered, one cycle behind the FSM state.
  - Captured data reaches the pins at the next DIG0 or DIG1 slot after a commit.
  - Worst case from load to visible: one frame + 1 cycle.
- Frame period: 2·(CLK_DIV+BLANK_CYCLES) cycles.
- At no cycle are both an bits asserted.
- Reset asserted mid-frame: every output goes to its inactive level asynchronously; no partial slot completes.

## Structure
- Shared package seg7_pkg holds:
  - SEG_OFF = 7'b0000000 and SEG_ZERO = 7'b1111110 constants;
  - the scan_state_t enum (DIG0, GAP0, DIG1, GAP1).
- Sub-module seg_scan_timer implements the slot counter and FSM. Its outputs are state and frame-entry pulses.
- The top level holds the buffers, pattern selection, blanking and output polarity registers.

## Test plan
All scenarios use CLK_DIV=4, BLANK_CYCLES=1, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0, LZ_BLANK=1.
- Reset and first frame: hold rst_n=0, then release with load=0 → seg=0 and an=2'b11 during reset; frame_start pulses once; the first frame shows an=2'b10 for 4 cycles, then 2'b11 for 1, then 2'b01 for 4, then 2'b11 for 1, with seg=0 throughout.
- Steady scan: load led_1=7'b1101101 ("2"), led_0=7'b1011011 ("5") → from the next frame, seg=7'b1011011 with an=2'b10, then seg=7'b1101101 with an=2'b01; period 10 cycles.
- Tear-free update: pulse load with "3"/"7" during DIG1 of the current frame → the remainder of that frame still shows "2"; the next frame shows "7" then "3".
- Leading zero: load led_1=7'b1111110, led_0=7'b0110000 → units shows "1"; during the tens slot, an=2'b11 and seg=0; frame length remains 10 cycles.
- Load on DIG0 entry: assert load on the exact entry cycle → the new data appears in that same frame (bypass).
- enable low mid-DIG1, reset mid-GAP0: enable=0 drives an=2'b11 the next cycle; after enable=1, the bench checks frame_start on the next edge and that DIG0 lasts a full 4 cycles. An async rst_n=0 in GAP0 drives outputs inactive immediately.
